// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache refill arbiter.
//   fill_state_e : arbiter FSM states (IDLE / FILL / TAG)
//   owner_e      : which cache currently owns the memory port
//   WORDS        : 16-bit words per 16-byte block
//   BLOCK_OFFSET_BITS : byte-offset bits stripped to form the block base
package cache_fill_arbiter_pkg;

    localparam int WORDS             = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int CNT_W             = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Clears the byte offset so the address points at the first word of its block.
    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & ~16'((1 << BLOCK_OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Beat counter used for both issued reads and received words.
//   clk, rst : core clock, async active-low reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment request; ignored once the terminal count is reached
//   cnt      : current count, 0..WORDS
//   done     : high when cnt == WORDS
module fill_counter
    import cache_fill_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = (cnt_q == CNT_W'(WORDS));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Refill arbiter between the I-/D-cache controllers and a shared pipelined
// main memory. Grants one cache on a miss (D has fixed priority), issues
// eight word reads, steers each returned word into the owner's data array,
// then writes the owner's tag/valid entry.
//
//   clk, rst                     : core clock, async active-low reset
//   I_Miss/I_Address, D_Miss/D_Address : miss requests from the caches
//   Mem_Data_In, Mem_Data_Valid  : returned read beats
//   Mem_Enable, Mem_Address      : read requests to memory
//   Fill_Data, Fill_Word_Num, Fill_Address : data-array write payload
//   *_Write_Data_Array, *_Write_Tag_Array  : per-cache write strobes
//   I_Stall, D_Stall, Busy       : pipeline hold / arbiter activity
//
// state | meaning
// IDLE  | no fill in progress; sample misses and grant
// FILL  | issue 8 reads, write each returned beat into the owner's data array
// TAG   | one-cycle tag/valid write for the owner
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
#(
    parameter int WORDS = cache_fill_arbiter_pkg::WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_Miss,
    input  logic [15:0] I_Address,
    input  logic        D_Miss,
    input  logic [15:0] D_Address,
    input  logic [15:0] Mem_Data_In,
    input  logic        Mem_Data_Valid,
    output logic        Mem_Enable,
    output logic [15:0] Mem_Address,
    output logic [15:0] Fill_Data,
    output logic [2:0]  Fill_Word_Num,
    output logic [15:0] Fill_Address,
    output logic        I_Write_Data_Array,
    output logic        I_Write_Tag_Array,
    output logic        D_Write_Data_Array,
    output logic        D_Write_Tag_Array,
    output logic        I_Stall,
    output logic        D_Stall,
    output logic        Busy
);

    fill_state_e      state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [15:0]      base_q, base_d;

    logic [CNT_W-1:0] iss_cnt, rcv_cnt;
    logic             iss_done, rcv_done;
    logic             cnt_clr, iss_inc, rcv_inc;

    // Counters are held at zero whenever idle, so a grant always starts clean.
    assign cnt_clr = (state_q == IDLE);
    assign iss_inc = (state_q == FILL) && !iss_done;
    assign rcv_inc = (state_q == FILL) && Mem_Data_Valid && !rcv_done;

    fill_counter u_iss (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (iss_inc),
        .cnt  (iss_cnt),
        .done (iss_done)
    );

    fill_counter u_rcv (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (rcv_inc),
        .cnt  (rcv_cnt),
        .done (rcv_done)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (D_Miss) begin
                    owner_d = OWN_D;
                    base_d  = block_base(D_Address);
                    state_d = FILL;
                end else if (I_Miss) begin
                    owner_d = OWN_I;
                    base_d  = block_base(I_Address);
                    state_d = FILL;
                end
            end
            FILL: begin
                // Leave on the cycle the last beat is written, so TAG follows it directly.
                if (rcv_inc && (rcv_cnt == CNT_W'(WORDS - 1))) begin
                    state_d = TAG;
                end
            end
            TAG:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
        end
    end

    assign Busy          = (state_q != IDLE);
    assign Mem_Enable    = iss_inc;
    assign Mem_Address   = iss_inc ? (base_q + 16'({iss_cnt, 1'b0})) : '0;
    assign Fill_Data     = Mem_Data_In;
    assign Fill_Word_Num = rcv_cnt[2:0];
    assign Fill_Address  = base_q;

    assign I_Write_Data_Array = rcv_inc && (owner_q == OWN_I);
    assign D_Write_Data_Array = rcv_inc && (owner_q == OWN_D);
    assign I_Write_Tag_Array  = (state_q == TAG) && (owner_q == OWN_I);
    assign D_Write_Tag_Array  = (state_q == TAG) && (owner_q == OWN_D);

    assign I_Stall = I_Miss || (Busy && (owner_q == OWN_I));
    assign D_Stall = D_Miss || (Busy && (owner_q == OWN_D));

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Sequences block refills for the I-cache and D-cache `cache_controller` instances from one shared, pipelined main memory. On a cache miss it grants the memory port to one cache and issues eight word reads. It steers each returning word into that cache's data array with the correct `Word_Num`, then writes the tag/valid entry. It sits between the two cache controllers and the memory module, and stalls the pipeline while a fill is outstanding.

## Interface

Parameters:
- WORDS, 8, words per 16-byte block; fixed at 8 because `Word_Num` is 3 bits.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- I_Miss  in  1  miss flag from the I-cache controller.
- I_Address  in  16  I-cache lookup address (byte address).
- D_Miss  in  1  miss flag from the D-cache controller.
- D_Address  in  16  D-cache lookup address (byte address).
- Mem_Data_In  in  16  read data from main memory.
- Mem_Data_Valid  in  1  Mem_Data_In carries one returned word this cycle.
- Mem_Enable  out  1  read request to memory this cycle.
- Mem_Address  out  16  read address, valid while Mem_Enable is high.
- Fill_Data  out  16  word to write into the data array; equals Mem_Data_In.
- Fill_Word_Num  out  3  word slot within the block for Fill_Data.
- Fill_Address  out  16  registered block base address, driven to the owner cache's Address input during a fill.
- I_Write_Data_Array, I_Write_Tag_Array  out  1 each  I-cache array write strobes.
- D_Write_Data_Array, D_Write_Tag_Array  out  1 each  D-cache array write strobes.
- I_Stall, D_Stall  out  1 each  hold the requester.
- Busy  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, FILL, TAG. Encoding lives in the package.
- IDLE:
  - If D_Miss is high, grant D. Otherwise, if I_Miss is high, grant I. D has fixed priority.
  - On a grant, register owner, register base = {Addr[15:4], 4'b0000}, clear both counters, and go to FILL.
- FILL:
  - Issue counter iss (0..8): while iss < 8, Mem_Enable = 1, Mem_Address = base + {iss, 1'b0}, and iss increments.
  - Receive counter rcv (0..8): each Mem_Data_Valid with rcv < 8 pulses the owner's Write_Data_Array, sets Fill_Word_Num = rcv[2:0], and increments rcv.
  - When rcv reaches 8, go to TAG.
- TAG: pulse the owner's Write_Tag_Array for exactly one cycle, then go to IDLE.
- Stalls:
  - I_Stall = I_Miss | (Busy & owner==I).
  - D_Stall = D_Miss | (Busy & owner==D).
- The non-owner's write strobes are always 0.
- Memory latency is not assumed; only valid beats are counted. Issue and receive may overlap in the same cycle.
- Boundary conditions:
  - Mem_Data_Valid in IDLE or TAG: ignored.
  - Beats beyond the 8th: ignored.
  - Owner's Miss drops mid-fill: the fill still completes; in-flight reads cannot be cancelled.
  - Non-owner miss during a fill: held (its stall is high) and granted in the IDLE cycle after TAG.
  - Reset mid-fill: return to IDLE at once and clear counters. Late memory beats are then ignored.
- Reset values: state IDLE, counters 0, every output 0, except Fill_Data, which follows Mem_Data_In.

## Timing

- Cycle 0: IDLE samples a miss and grants.
- Cycles 1-8: one read issued per cycle, addresses base+0 through base+14.
- Write latency: data-array write in the same cycle as each valid beat, with no added latency.
- With 4-cycle memory:
  - Beats arrive in cycles 5-12.
  - TAG is cycle 13.
  - IDLE is cycle 14; a new grant is possible in cycle 14.
- Miss-to-hit: the cache controller sees a hit in cycle 14, because Miss is combinational on the tag array.
- Output registration:
  - Mem_Enable, Mem_Address and the Write_Tag strobes are decoded from registered state and counters.
  - The Write_Data strobes are combinational from Mem_Data_Valid.

## Structure

- Shared package holds:
  - state localparams IDLE/FILL/TAG;
  - owner encoding OWN_I=0, OWN_D=1;
  - WORDS=8;
  - BLOCK_OFFSET_BITS=4.
- Sub-module `fill_counter`: 4-bit counter with synchronous clear, increment enable, and terminal flag at 8. It is instantiated twice, for iss and rcv.

## Test plan

- D_Miss, D_Address=16'h1236, 4-cycle memory:
  - Mem_Address runs 0x1230, 0x1232, …, 0x123E in cycles 1-8.
  - D_Write_Data_Array pulses in cycles 5-12 with Word_Num 0-7.
  - D_Write_Tag_Array fires in cycle 13; Busy falls in cycle 14.
- I_Miss and D_Miss in the same cycle:
  - D fill completes first; I_Stall stays high throughout.
  - I fill starts in cycle 14 at base {I_Address[15:4], 0}.
- Variable memory latency, 1-6 cycles per beat with gaps:
  - Exactly 8 data writes occur, Word_Num in order.
  - TAG comes one cycle after the 8th beat.
- Reset asserted at cycle 6 of a fill, with late valid beats afterwards:
  - All outputs go to 0 immediately.
  - No array writes occur; state stays IDLE.
- Stray Mem_Data_Valid in IDLE, then a 9th beat during TAG: no write strobes are produced.
- Owner Miss deasserted in cycle 3: fill still issues 8 reads and writes the tag.
